// File: rtl/serializer_if.sv
// ---------------------------------------------------------------------------
// serializer_if
//   Handshake and serial-output bundle for the serializer.
//   Parameter Wdata : parallel word width in bits.
//   Signals:
//     IN        parallel word from the source
//     IN_VALID  IN holds a word to transfer
//     IN_READY  serializer can accept a word this cycle
//     OUT       serial data bit
//     OUT_VALID OUT carries a valid bit
//     OUT_FIRST current bit is the first bit of its word
//     OUT_LAST  current bit is the last bit of its word
//   Modports: master = word source / bit sink, slave = serializer.
// ---------------------------------------------------------------------------
interface serializer_if #(
   parameter int Wdata = 8
);
   logic [Wdata-1:0] IN;
   logic             IN_VALID;
   logic             IN_READY;
   logic             OUT;
   logic             OUT_VALID;
   logic             OUT_FIRST;
   logic             OUT_LAST;

   modport master (
      output IN, IN_VALID,
      input  IN_READY, OUT, OUT_VALID, OUT_FIRST, OUT_LAST
   );

   modport slave (
      input  IN, IN_VALID,
      output IN_READY, OUT, OUT_VALID, OUT_FIRST, OUT_LAST
   );
endinterface

// File: rtl/serializer.sv
// ---------------------------------------------------------------------------
// serializer
//   Parallel-to-serial converter. Words arrive on a valid/ready handshake and
//   leave one bit per clock with first/last-of-word strobes. A one-word
//   holding buffer lets the next word wait while the current one shifts, so
//   a continuously valid source produces a gapless bit stream.
//   Parameters:
//     Wdata    word width in bits (>= 1)
//     Msbfirst 0: bit 0 leaves first, 1: bit Wdata-1 leaves first
//   Ports:
//     CLK  clock, rising edge
//     RST  asynchronous active-high reset
//     bus  serializer_if.slave (IN/IN_VALID/IN_READY, OUT/OUT_VALID/
//          OUT_FIRST/OUT_LAST)
// ---------------------------------------------------------------------------
module serializer #(
   parameter int Wdata    = 8,
   parameter bit Msbfirst = 1'b0
) (
   input  logic         CLK,
   input  logic         RST,
   serializer_if.slave  bus
);

   localparam int             CW       = (Wdata > 1) ? $clog2(Wdata) : 1;
   localparam int             OUT_IDX  = Msbfirst ? Wdata - 1 : 0;
   localparam logic [CW-1:0]  CNT_LAST = CW'(Wdata - 1);
   localparam logic           ONE_BIT  = (Wdata == 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [Wdata-1:0] sr;
   logic [Wdata-1:0] sr_shift;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic [Wdata-1:0] hb;
   logic             hb_full;

   logic             out_bit;
   logic             out_valid;
   logic             out_first;
   logic             out_last;

   logic             free;
   logic             transfer;

   // Shift toward the output end; a one-bit word never shifts.
   generate
      if (Wdata == 1) begin : g_one
         assign sr_shift = sr;
      end else if (Msbfirst) begin : g_msb
         assign sr_shift = {sr[Wdata-2:0], 1'b0};
      end else begin : g_lsb
         assign sr_shift = {1'b0, sr[Wdata-1:1]};
      end
   endgenerate

   assign cnt_inc  = cnt + 1'b1;

   // The shifter can take a new word when idle or while its last bit is out.
   assign free     = (state == IDLE) || (cnt == CNT_LAST);

   // NOTE: ready is gated by RST combinationally so it drops the moment reset
   // asserts; it never looks at IN_VALID, which avoids a valid/ready loop.
   assign bus.IN_READY = !RST && !hb_full;
   assign transfer     = bus.IN_VALID && bus.IN_READY;

   // Single state machine; outputs are registered alongside the state so
   // they reflect the bit loaded or shifted at the same edge.
   // NOTE: every register here uses <= so all updates see pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         hb        <= '0;
         hb_full   <= 1'b0;
         out_bit   <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else if (free && hb_full) begin
         // Buffered word has priority; IN_READY was low so no transfer now.
         state     <= SHIFT;
         sr        <= hb;
         cnt       <= '0;
         hb_full   <= 1'b0;
         out_bit   <= hb[OUT_IDX];
         out_valid <= 1'b1;
         out_first <= 1'b1;
         out_last  <= ONE_BIT;
      end else if (free && transfer) begin
         // Bypass: the incoming word goes straight into the shifter.
         state     <= SHIFT;
         sr        <= bus.IN;
         cnt       <= '0;
         out_bit   <= bus.IN[OUT_IDX];
         out_valid <= 1'b1;
         out_first <= 1'b1;
         out_last  <= ONE_BIT;
      end else if (free) begin
         state     <= IDLE;
         out_bit   <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         cnt       <= cnt_inc;
         sr        <= sr_shift;
         out_bit   <= sr_shift[OUT_IDX];
         out_valid <= 1'b1;
         out_first <= 1'b0;
         out_last  <= (cnt_inc == CNT_LAST);
         if (transfer) begin
            hb      <= bus.IN;
            hb_full <= 1'b1;
         end
      end
   end

   assign bus.OUT       = out_bit;
   assign bus.OUT_VALID = out_valid;
   assign bus.OUT_FIRST = out_first;
   assign bus.OUT_LAST  = out_last;

endmodule

// File: tb/tb_serializer.sv
// ---------------------------------------------------------------------------
// tb_serializer
//   Drives three serializers (Wdata=8 LSB-first, Wdata=8 MSB-first, Wdata=1)
//   from per-instance word queues and compares every output cycle against a
//   bit-stream reference: each accepted word is expanded into its bits, and
//   one bit is consumed per clock.
// ---------------------------------------------------------------------------
module tb_serializer;

   localparam int N = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   serializer_if #(.Wdata(8)) bus0 ();
   serializer_if #(.Wdata(8)) bus1 ();
   serializer_if #(.Wdata(1)) bus2 ();

   serializer #(.Wdata(8), .Msbfirst(1'b0)) u_lsb (.CLK(CLK), .RST(RST), .bus(bus0));
   serializer #(.Wdata(8), .Msbfirst(1'b1)) u_msb (.CLK(CLK), .RST(RST), .bus(bus1));
   serializer #(.Wdata(1), .Msbfirst(1'b0)) u_one (.CLK(CLK), .RST(RST), .bus(bus2));

   logic [7:0]   drv_data [N];
   logic [N-1:0] drv_valid;

   assign bus0.IN       = drv_data[0];
   assign bus1.IN       = drv_data[1];
   assign bus2.IN       = drv_data[2][0:0];
   assign bus0.IN_VALID = drv_valid[0];
   assign bus1.IN_VALID = drv_valid[1];
   assign bus2.IN_VALID = drv_valid[2];

   logic [N-1:0] obs_ready, obs_out, obs_valid, obs_first, obs_last;
   assign obs_ready = {bus2.IN_READY,  bus1.IN_READY,  bus0.IN_READY};
   assign obs_out   = {bus2.OUT,       bus1.OUT,       bus0.OUT};
   assign obs_valid = {bus2.OUT_VALID, bus1.OUT_VALID, bus0.OUT_VALID};
   assign obs_first = {bus2.OUT_FIRST, bus1.OUT_FIRST, bus0.OUT_FIRST};
   assign obs_last  = {bus2.OUT_LAST,  bus1.OUT_LAST,  bus0.OUT_LAST};

   // Reference: queue of bits still to appear on the serial side.
   typedef struct packed {
      logic b;
      logic first;
      logic last;
   } ent_t;

   ent_t        q   [N][$];
   logic [7:0]  src [N][$];
   int          width [N] = '{8, 8, 1};
   bit          msb   [N] = '{1'b0, 1'b1, 1'b0};
   bit          rst_model;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Words still owned by the block: one shifting plus at most one buffered.
   function automatic int words(input int i);
      int n = 0;
      for (int k = 0; k < q[i].size(); k++)
         if (q[i][k].last) n++;
      return n;
   endfunction

   task automatic push_word(input int i, input logic [7:0] w);
      ent_t e;
      for (int b = 0; b < width[i]; b++) begin
         e.b     = w[msb[i] ? width[i] - 1 - b : b];
         e.first = (b == 0);
         e.last  = (b == width[i] - 1);
         q[i].push_back(e);
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < N; i++) begin
         if (q[i].size() != 0) begin
            check($sformatf("valid%0d", i), obs_valid[i], 1);
            check($sformatf("out%0d",   i), obs_out[i],   q[i][0].b);
            check($sformatf("first%0d", i), obs_first[i], q[i][0].first);
            check($sformatf("last%0d",  i), obs_last[i],  q[i][0].last);
         end else begin
            check($sformatf("valid%0d", i), obs_valid[i], 0);
            check($sformatf("first%0d", i), obs_first[i], 0);
            check($sformatf("last%0d",  i), obs_last[i],  0);
         end
      end
   endtask

   // One clock: drive, check ready, advance the reference at the edge, check
   // outputs just after the edge.
   task automatic step(input int stall_pct);
      bit rdy [N];
      for (int i = 0; i < N; i++) begin
         drv_valid[i] = (src[i].size() != 0) && ($urandom_range(99) >= stall_pct);
         drv_data[i]  = drv_valid[i] ? src[i][0] : 8'($urandom);
      end
      #1;
      for (int i = 0; i < N; i++) begin
         rdy[i] = !rst_model && (words(i) < 2);
         check($sformatf("ready%0d", i), obs_ready[i], rdy[i]);
      end
      @(posedge CLK);
      for (int i = 0; i < N; i++) begin
         if (rst_model) begin
            q[i].delete();
         end else begin
            if (q[i].size() != 0) void'(q[i].pop_front());
            if (drv_valid[i] && rdy[i]) begin
               push_word(i, src[i][0]);
               void'(src[i].pop_front());
            end
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic push_all(input logic [7:0] w);
      for (int i = 0; i < N; i++) src[i].push_back(w);
   endtask

   initial begin
      rst_model = 1'b1;
      drv_valid = '0;
      for (int i = 0; i < N; i++) drv_data[i] = '0;

      // Reset state
      #2;
      check_outputs();
      for (int i = 0; i < N; i++) check($sformatf("rst_ready%0d", i), obs_ready[i], 0);
      repeat (2) @(posedge CLK);
      #3;
      RST = 1'b0;
      rst_model = 1'b0;

      // Single word, then idle
      push_all(8'hA5);
      repeat (11) step(0);

      // Second single word (0F) for the bit-order check
      push_all(8'h0F);
      repeat (10) step(0);

      // Back-to-back stream
      push_all(8'h01);
      push_all(8'h80);
      push_all(8'hFF);
      repeat (28) step(0);

      // Source stall of 5 cycles between words
      push_all(8'hC3);
      repeat (9) step(0);
      repeat (5) step(100);
      push_all(8'h3C);
      repeat (10) step(0);

      // Reset mid-word: A5 shifting (bit 3 on OUT), 3C held in the buffer
      push_all(8'hA5);
      push_all(8'h3C);
      repeat (4) step(0);
      #2;
      RST = 1'b1;
      rst_model = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("arst_valid%0d", i), obs_valid[i], 0);
         check($sformatf("arst_out%0d",   i), obs_out[i],   0);
         check($sformatf("arst_first%0d", i), obs_first[i], 0);
         check($sformatf("arst_last%0d",  i), obs_last[i],  0);
         check($sformatf("arst_ready%0d", i), obs_ready[i], 0);
         q[i].delete();
         src[i].delete();
      end
      repeat (2) step(0);
      #2;
      RST = 1'b0;
      rst_model = 1'b0;
      push_all(8'h5A);
      repeat (11) step(0);

      // One-bit words 1,0,1,1 held valid
      src[2].push_back(8'h01);
      src[2].push_back(8'h00);
      src[2].push_back(8'h01);
      src[2].push_back(8'h01);
      repeat (6) step(0);

      // Randomized traffic with varying stall density
      for (int seg = 0; seg < 8; seg++) begin
         int stall;
         stall = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 30 : 70);
         for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++)
               if (src[i].size() < 3 && $urandom_range(3) != 0)
                  src[i].push_back(8'($urandom));
            step(stall);
         end
      end

      // Drain
      for (int i = 0; i < N; i++) src[i].delete();
      repeat (20) step(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
